pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: owns hold/flush priority for PC, IF/ID and ID/EX.
// Define PIPE_STALL_CNT_EN to build the stall-cycle counter behind stall_cnt_o.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MC_TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        ex_mem_rd_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        mc_start_i,
    input  logic        mc_done_i,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        mc_abort_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MC_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    localparam logic [1:0] FCNT_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TCNT_LAST   = 8'(MC_TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       load_use;

    // Stores carry rd=0 and unused sources read as 0, so x0 never hazards.
    assign load_use = ex_mem_rd_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

    assign jump_addr_o = jump_i ? jump_addr_i : '0;

    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        tcnt_d        = tcnt_q;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        jump_flag_o   = 1'b0;
        mc_abort_o    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (jump_i) begin
                    jump_flag_o   = 1'b1;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FCNT_RELOAD;
                    end
                end else if (mc_start_i) begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                    state_d      = ST_MC_WAIT;
                    tcnt_d       = '0;
                end else if (load_use) begin
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                // Completion takes precedence over a coincident timeout.
                if (mc_done_i) begin
                    state_d = ST_RUN;
                end else if (tcnt_q == TCNT_LAST) begin
                    mc_abort_o = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                    tcnt_d       = tcnt_q + 8'd1;
                end
            end
            ST_FLUSH: begin
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
                if (jump_i) begin
                    jump_flag_o = 1'b1;
                    fcnt_d      = FCNT_RELOAD;
                end else begin
                    fcnt_d = fcnt_q - 2'd1;
                    if (fcnt_q == 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hold_pc_o) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (FLUSH_CYCLES=2/MC_TIMEOUT=4 and
// FLUSH_CYCLES=1/MC_TIMEOUT=16) share stimulus; expected outputs are queued per cycle.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_rd, jump, mc_start, mc_done;
    logic [31:0] jump_addr;

    logic        a_hpc, a_hifid, a_hidex, a_fifid, a_fidex, a_jf, a_ab;
    logic        b_hpc, b_hifid, b_hidex, b_fifid, b_fidex, b_jf, b_ab;
    logic [31:0] a_jaddr, b_jaddr, a_stall, b_stall;
    logic [6:0]  a_ctl, b_ctl;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(2), .MC_TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_mem_rd_i(ex_mem_rd), .ex_rd_i(ex_rd), .jump_i(jump), .jump_addr_i(jump_addr),
        .mc_start_i(mc_start), .mc_done_i(mc_done),
        .hold_pc_o(a_hpc), .hold_if_id_o(a_hifid), .hold_id_ex_o(a_hidex),
        .flush_if_id_o(a_fifid), .flush_id_ex_o(a_fidex), .jump_flag_o(a_jf),
        .jump_addr_o(a_jaddr), .mc_abort_o(a_ab), .stall_cnt_o(a_stall)
    );

    pipe_ctrl #(.FLUSH_CYCLES(1), .MC_TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_mem_rd_i(ex_mem_rd), .ex_rd_i(ex_rd), .jump_i(jump), .jump_addr_i(jump_addr),
        .mc_start_i(mc_start), .mc_done_i(mc_done),
        .hold_pc_o(b_hpc), .hold_if_id_o(b_hifid), .hold_id_ex_o(b_hidex),
        .flush_if_id_o(b_fifid), .flush_id_ex_o(b_fidex), .jump_flag_o(b_jf),
        .jump_addr_o(b_jaddr), .mc_abort_o(b_ab), .stall_cnt_o(b_stall)
    );

    // {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_flag, mc_abort}
    assign a_ctl = {a_hpc, a_hifid, a_hidex, a_fifid, a_fidex, a_jf, a_ab};
    assign b_ctl = {b_hpc, b_hifid, b_hidex, b_fifid, b_fidex, b_jf, b_ab};

    localparam logic [6:0] C0  = 7'b0000000;
    localparam logic [6:0] CLU = 7'b1100100;
    localparam logic [6:0] CJ  = 7'b0001110;
    localparam logic [6:0] CF  = 7'b0001100;
    localparam logic [6:0] CH  = 7'b1110000;
    localparam logic [6:0] CAB = 7'b0000001;

`ifdef PIPE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        mem;
        logic [4:0]  rd;
        logic        jmp;
        logic [31:0] ja;
        logic        mcs;
        logic        mcd;
        logic [6:0]  ea;
        logic [6:0]  eb;
        logic [31:0] eaddr;
    } vec_t;

    typedef struct {
        logic [6:0]  ea;
        logic [6:0]  eb;
        logic [31:0] eaddr;
        int          idx;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[31];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic mem,
                                input logic [4:0] rd, input logic jmp, input logic [31:0] ja,
                                input logic mcs, input logic mcd, input logic [6:0] ea,
                                input logic [6:0] eb, input logic [31:0] eaddr);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.mem = mem; v.rd = rd; v.jmp = jmp; v.ja = ja;
        v.mcs = mcs; v.mcd = mcd; v.ea = ea; v.eb = eb; v.eaddr = eaddr;
        return v;
    endfunction

    function automatic vec_t idle(input logic [6:0] ea, input logic [6:0] eb);
        return mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, ea, eb, 32'd0);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; ex_mem_rd = v.mem; ex_rd = v.rd;
        jump = v.jmp; jump_addr = v.ja; mc_start = v.mcs; mc_done = v.mcd;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v);
        e.ea = v.ea; e.eb = v.eb; e.eaddr = v.eaddr; e.idx = idx;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        check("ctl_a",  e.idx, 32'(a_ctl), 32'(e.ea));
        check("ctl_b",  e.idx, 32'(b_ctl), 32'(e.eb));
        check("addr_a", e.idx, a_jaddr, e.eaddr);
        check("addr_b", e.idx, b_jaddr, e.eaddr);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctl_a"}, 0, 32'(a_ctl), 32'd0);
        check({name, "_ctl_b"}, 0, 32'(b_ctl), 32'd0);
        check({name, "_addr_a"}, 0, a_jaddr, 32'd0);
        check({name, "_stall_a"}, 0, a_stall, 32'd0);
        check({name, "_stall_b"}, 0, b_stall, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        tbl[0]  = idle(C0, C0);
        tbl[1]  = mk(5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 32'd0, 1'b0, 1'b0, CLU, CLU, 32'd0);
        tbl[2]  = idle(C0, C0);
        tbl[3]  = mk(5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, C0, C0, 32'd0);
        tbl[4]  = mk(5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 32'd0, 1'b0, 1'b0, CLU, CLU, 32'd0);
        tbl[5]  = mk(5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 32'd0, 1'b0, 1'b0, C0, C0, 32'd0);
        tbl[6]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h100, 1'b0, 1'b0, CJ, CJ, 32'h100);
        tbl[7]  = idle(CF, C0);
        tbl[8]  = idle(C0, C0);
        tbl[9]  = mk(5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 32'h200, 1'b1, 1'b0, CJ, CJ, 32'h200);
        tbl[10] = idle(CF, C0);
        tbl[11] = idle(C0, C0);
        tbl[12] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h300, 1'b0, 1'b0, CJ, CJ, 32'h300);
        tbl[13] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h304, 1'b0, 1'b0, CJ, CJ, 32'h304);
        tbl[14] = idle(CF, C0);
        tbl[15] = idle(C0, C0);
        tbl[16] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1, C0, C0, 32'd0);
        tbl[17] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, CH, CH, 32'd0);
        tbl[18] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 32'd0, 1'b0, 1'b0, CH, CH, 32'd0);
        tbl[19] = mk(5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 32'd0, 1'b0, 1'b0, CH, CH, 32'd0);
        tbl[20] = idle(CH, CH);
        tbl[21] = idle(CAB, CH);
        tbl[22] = idle(C0, CH);
        tbl[23] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1, C0, C0, 32'd0);
        tbl[24] = idle(C0, C0);
        tbl[25] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, CH, CH, 32'd0);
        tbl[26] = idle(CH, CH);
        tbl[27] = idle(CH, CH);
        tbl[28] = idle(CH, CH);
        tbl[29] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1, C0, C0, 32'd0);
        tbl[30] = idle(C0, C0);

        rst_n = 1'b0;
        drive(idle(C0, C0));
        #3;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            apply(tbl[i], i);
        end

        // Divider: done arrives 10 cycles after start; dut_a times out at its 4th wait cycle.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            v = idle(c < 4 ? CH : (c == 4 ? CAB : C0), c < 10 ? CH : C0);
            v.mcs = (c == 0);
            v.mcd = (c == 10);
            apply(v, 100 + c);
        end
        @(posedge clk);
        #1;
        drive(idle(C0, C0));
        check("stall_cnt_b", 111, b_stall, CNT_EN ? 32'd10 : 32'd0);
        check("stall_cnt_a", 111, a_stall, CNT_EN ? 32'd4 : 32'd0);

        // Asynchronous reset while both instances sit in MC_WAIT.
        v = idle(CH, CH);
        v.mcs = 1'b1;
        apply(v, 200);
        apply(idle(CH, CH), 201);
        apply(idle(CH, CH), 202);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            apply(idle(C0, C0), 210 + c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
